// File: rtl/tcon_timing_monitor_if.sv
// Display timing stream plus published frame results for the TCON
// timing monitor.
//   master : timing source / result consumer (drives vsync, de, r/g/b_in)
//   slave  : the monitor (drives frame_done, width/height_meas, line_err,
//            frame_err, err_cnt, checksum)
interface tcon_timing_monitor_if #(
  parameter int DW = 12
);
  logic            vsync;
  logic            de;
  logic [DW-1:0]   r_in;
  logic [DW-1:0]   g_in;
  logic [DW-1:0]   b_in;
  logic            frame_done;
  logic [11:0]     width_meas;
  logic [11:0]     height_meas;
  logic            line_err;
  logic            frame_err;
  logic [7:0]      err_cnt;
  logic [3*DW-1:0] checksum;

  modport master (
    output vsync, de, r_in, g_in, b_in,
    input  frame_done, width_meas, height_meas, line_err, frame_err,
           err_cnt, checksum
  );

  modport slave (
    input  vsync, de, r_in, g_in, b_in,
    output frame_done, width_meas, height_meas, line_err, frame_err,
           err_cnt, checksum
  );
endinterface

// File: rtl/tcon_timing_monitor.sv
// TCON timing monitor: watches a vsync/de display stream, measures the first
// line width and the line count of each frame, flags lines whose pixel count
// differs from WIDTH, and folds every active pixel into a rotate-XOR
// signature. Results are published with a one-cycle frame_done pulse and held
// until the next pulse.
//   clk : clock, all flops on posedge
//   rst : synchronous active-high reset
//   bus : tcon_timing_monitor_if.slave
//         in : vsync, de, r_in/g_in/b_in
//         out: frame_done, width_meas, height_meas, line_err, frame_err,
//              err_cnt (saturating errored-frame count), checksum
module tcon_timing_monitor #(
  parameter int DW     = 12,
  parameter int WIDTH  = 24,
  parameter int HEIGHT = 36
) (
  input  logic                 clk,
  input  logic                 rst,
  tcon_timing_monitor_if.slave bus
);
  localparam int CW = 3 * DW;

  typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE, HBLANK} state_e;

  state_e        state_q;
  logic          vsync_q, de_q;
  logic [11:0]   pix_cnt_q, line_cnt_q, first_w_q;
  logic [CW-1:0] acc_q;
  logic          lerr_q;

  logic          frame_done_q;
  logic [11:0]   width_meas_q, height_meas_q;
  logic          line_err_q, frame_err_q;
  logic [7:0]    err_cnt_q;
  logic [CW-1:0] checksum_q;

  logic          vs_rise, de_rise, de_fall;
  logic          pix_vld, line_bad, last_line, frame_bad;
  logic [11:0]   pix_cnt_d, first_w_d;
  logic [CW-1:0] acc_d;
  logic [7:0]    err_cnt_d;

  assign vs_rise = bus.vsync & ~vsync_q;
  assign de_rise = bus.de & ~de_q;
  assign de_fall = ~bus.de & de_q;

  // A pixel counts in ACTIVE, or on the de_rise cycle that enters ACTIVE.
  // de seen in IDLE (or a de already high when the frame opened) is ignored.
  assign pix_vld = bus.de & ((state_q == ACTIVE) |
                   (de_rise & ((state_q == VBLANK) | (state_q == HBLANK))));

  assign pix_cnt_d = de_rise ? 12'd1 :
                     (pix_cnt_q == 12'hFFF) ? pix_cnt_q : pix_cnt_q + 12'd1;
  assign acc_d     = {acc_q[CW-2:0], acc_q[CW-1]} ^ {bus.r_in, bus.g_in, bus.b_in};

  // Evaluated on de_fall: pix_cnt_q then holds the finished line's length.
  assign line_bad  = (pix_cnt_q != 12'(WIDTH));
  assign last_line = (line_cnt_q == 12'(HEIGHT - 1));
  assign frame_bad = lerr_q | line_bad;
  // Bypass so a one-line frame still publishes its own width.
  assign first_w_d = (line_cnt_q == 12'd0) ? pix_cnt_q : first_w_q;
  assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      vsync_q       <= 1'b0;
      de_q          <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      first_w_q     <= '0;
      acc_q         <= '0;
      lerr_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      width_meas_q  <= '0;
      height_meas_q <= '0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      err_cnt_q     <= '0;
      checksum_q    <= '0;
    end else begin
      vsync_q      <= bus.vsync;
      de_q         <= bus.de;
      frame_done_q <= 1'b0;

      if (vs_rise) begin
        // vs_rise wins over a same-cycle de_fall: the partial line is not
        // counted, the open frame is published as aborted, a new one starts.
        if (state_q != IDLE) begin
          frame_done_q  <= 1'b1;
          width_meas_q  <= first_w_q;
          height_meas_q <= line_cnt_q;
          line_err_q    <= lerr_q;
          frame_err_q   <= 1'b1;
          checksum_q    <= acc_q;
          err_cnt_q     <= err_cnt_d;
        end
        pix_cnt_q  <= '0;
        line_cnt_q <= '0;
        first_w_q  <= '0;
        acc_q      <= '0;
        lerr_q     <= 1'b0;
        state_q    <= VBLANK;
      end else begin
        if (pix_vld) begin
          pix_cnt_q <= pix_cnt_d;
          acc_q     <= acc_d;
        end

        case (state_q)
          VBLANK, HBLANK: begin
            if (de_rise) state_q <= ACTIVE;
          end
          ACTIVE: begin
            if (de_fall) begin
              line_cnt_q <= line_cnt_q + 12'd1;
              first_w_q  <= first_w_d;
              lerr_q     <= frame_bad;
              if (last_line) begin
                frame_done_q  <= 1'b1;
                width_meas_q  <= first_w_d;
                height_meas_q <= 12'(HEIGHT);
                line_err_q    <= frame_bad;
                frame_err_q   <= frame_bad;
                checksum_q    <= acc_q;
                if (frame_bad) err_cnt_q <= err_cnt_d;
                state_q <= IDLE;
              end else begin
                state_q <= HBLANK;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.frame_done  = frame_done_q;
  assign bus.width_meas  = width_meas_q;
  assign bus.height_meas = height_meas_q;
  assign bus.line_err    = line_err_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.checksum    = checksum_q;

endmodule

// File: tb/tb_tcon_timing_monitor.sv
// Bench for tcon_timing_monitor: constant-expectation frame table, randomized
// frames against a frame-level model, and hand-written corner sequences
// (coincident vsync/de_fall, mid-frame reset, err_cnt saturation).
module tb_tcon_timing_monitor;
  localparam int DW     = 12;
  localparam int WIDTH  = 24;
  localparam int HEIGHT = 36;
  localparam int CW     = 3 * DW;
  localparam logic [CW-1:0] PIX1 = {12'h001, 24'h0};

  typedef struct packed {
    logic [11:0]   w;
    logic [11:0]   h;
    logic          le;
    logic          fe;
    logic [7:0]    ec;
    logic [CW-1:0] cs;
  } res_t;

  typedef struct {
    int   sidx;   // index of the odd-length line, -1 for none
    int   slen;
    int   abort;  // lines sent before the next vsync, 0 = full frame
    int   pmode;  // 0 zero pixels, 1 random, 2 only first pixel = PIX1
    res_t exp;
    bit   csv;    // checksum is a fixed constant for this row
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tcon_timing_monitor_if #(.DW(DW)) bus ();

  tcon_timing_monitor #(.DW(DW), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   nd     = 0;
  int   stab_bad = 0;
  res_t got_q[$];
  res_t exp_q[$];
  res_t snap;

  // frame-level reference model
  bit            m_open = 1'b0;
  int            m_lens[$];
  logic [CW-1:0] m_acc = '0;
  int            m_fpix = 0;
  int            m_ec = 0;

  function automatic res_t sample();
    res_t r;
    r.w  = bus.width_meas;
    r.h  = bus.height_meas;
    r.le = bus.line_err;
    r.fe = bus.frame_err;
    r.ec = bus.err_cnt;
    r.cs = bus.checksum;
    return r;
  endfunction

  function automatic res_t mk(int w, int h, bit le, bit fe, int ec, logic [CW-1:0] cs);
    res_t r;
    r.w = 12'(w); r.h = 12'(h); r.le = le; r.fe = fe; r.ec = 8'(ec); r.cs = cs;
    return r;
  endfunction

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) begin
      got_q.push_back(sample());
      nd++;
    end
    if (rst || bus.frame_done === 1'b1) snap = sample();
    else if (sample() !== snap) stab_bad++;
  end

  function automatic void m_publish(bit abort);
    res_t e;
    bit   le = 1'b0;
    foreach (m_lens[i]) if (m_lens[i] != WIDTH) le = 1'b1;
    e.w  = (m_lens.size() > 0) ? 12'(m_lens[0]) : 12'd0;
    e.h  = 12'(m_lens.size());
    e.le = le;
    e.fe = abort | le;
    e.cs = m_acc;
    if (e.fe && m_ec < 255) m_ec++;
    e.ec = 8'(m_ec);
    exp_q.push_back(e);
  endfunction

  function automatic void m_vs();
    if (m_open) m_publish(1'b1);
    m_open = 1'b1;
    m_lens.delete();
    m_acc  = '0;
    m_fpix = 0;
  endfunction

  function automatic void m_line(int len);
    m_lens.push_back(len);
    if (m_lens.size() == HEIGHT) begin
      m_publish(1'b0);
      m_open = 1'b0;
    end
  endfunction

  function automatic void m_pix(logic [CW-1:0] px);
    if (m_open) begin
      m_acc = ((m_acc << 1) | (m_acc >> (CW - 1))) ^ px;
      m_fpix++;
    end
  endfunction

  function automatic logic [CW-1:0] gen_px(int pmode);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case (pmode)
      1:       return r[CW-1:0];
      2:       return (m_fpix == 0) ? PIX1 : '0;
      default: return '0;
    endcase
  endfunction

  task automatic step(input logic vs, input logic d, input logic [CW-1:0] px);
    bus.vsync = vs;
    bus.de    = d;
    bus.r_in  = px[3*DW-1:2*DW];
    bus.g_in  = px[2*DW-1:DW];
    bus.b_in  = px[DW-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic do_line(input int len, input int pmode, input int hbp, input int hfp);
    logic [CW-1:0] px;
    repeat (hbp) step(1'b0, 1'b0, '0);
    for (int p = 0; p < len; p++) begin
      px = gen_px(pmode);
      m_pix(px);
      step(1'b0, 1'b1, px);
    end
    if (m_open) m_line(len);
    repeat (hfp) step(1'b0, 1'b0, '0);
  endtask

  task automatic do_frame(input int sidx, input int slen, input int abort, input int pmode,
                          input bit rnd, input int hbp, input int hfp, input int vbp,
                          input int vfp);
    int nl;
    int len;
    step(1'b1, 1'b0, '0);
    m_vs();
    step(1'b1, 1'b0, '0);
    repeat (vbp) step(1'b0, 1'b0, '0);
    nl = (abort > 0) ? abort : HEIGHT;
    for (int l = 0; l < nl; l++) begin
      len = WIDTH;
      if (rnd) begin
        if ($urandom_range(0, 7) == 0) len = WIDTH - 2 + int'($urandom_range(0, 4));
      end else if (l == sidx) begin
        len = slen;
      end
      do_line(len, pmode, hbp, hfp);
    end
    repeat (vfp) step(1'b0, 1'b0, '0);
  endtask

  task automatic cmp(input string nm, input res_t g, input res_t e, input bit cs);
    checks++;
    if (g.w !== e.w || g.h !== e.h || g.le !== e.le || g.fe !== e.fe ||
        g.ec !== e.ec || (cs && g.cs !== e.cs)) begin
      errors++;
      $display("FAIL %s got w=%0d h=%0d le=%0b fe=%0b ec=%0d cs=%h need w=%0d h=%0d le=%0b fe=%0b ec=%0d cs=%h",
               nm, g.w, g.h, g.le, g.fe, g.ec, g.cs, e.w, e.h, e.le, e.fe, e.ec, e.cs);
    end
  endtask

  task automatic chk(input string nm, input int g, input int e);
    checks++;
    if (g != e) begin
      errors++;
      $display("FAIL %s got %0d need %0d", nm, g, e);
    end
  endtask

  row_t tbl[7];
  int   ti = 0;

  task automatic drain(input bit use_tbl);
    res_t g;
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_frame_done got h=%0d need none", g.h);
      end else begin
        cmp("model", g, exp_q.pop_front(), 1'b1);
      end
      if (use_tbl) begin
        if (ti < 7) cmp($sformatf("tbl%0d", ti), g, tbl[ti].exp, tbl[ti].csv);
        ti++;
      end
    end
    chk("missing_frame_done", exp_q.size(), 0);
  endtask

  initial begin
    int nd0;
    logic [CW-1:0] px;

    tbl[0] = '{-1,  0,  0, 0, mk(24, 36, 0, 0, 0, '0),            1'b1};
    tbl[1] = '{ 4, 23,  0, 1, mk(24, 36, 1, 1, 1, '0),            1'b0};
    tbl[2] = '{-1,  0,  0, 2, mk(24, 36, 0, 0, 1, 36'h000800000), 1'b1};
    tbl[3] = '{-1,  0, 20, 0, mk(24, 20, 0, 1, 2, '0),            1'b1};
    tbl[4] = '{-1,  0,  0, 1, mk(24, 36, 0, 0, 2, '0),            1'b0};
    tbl[5] = '{ 0, 25,  0, 0, mk(25, 36, 1, 1, 3, '0),            1'b1};
    tbl[6] = '{35, 20,  0, 0, mk(24, 36, 1, 1, 4, '0),            1'b1};

    bus.vsync = 1'b0; bus.de = 1'b0;
    bus.r_in = '0; bus.g_in = '0; bus.b_in = '0;
    rst = 1'b1;
    repeat (3) step(1'b0, 1'b0, '0);
    rst = 1'b0;
    step(1'b0, 1'b0, '0);
    cmp("reset_outputs", sample(), mk(0, 0, 0, 0, 0, '0), 1'b1);
    chk("reset_frame_done", int'(bus.frame_done), 0);

    // nominal timing: HSYNC 1 + back porch 10, front porch 10, V porches one line
    for (int i = 0; i < 7; i++) begin
      do_frame(tbl[i].sidx, tbl[i].slen, tbl[i].abort, tbl[i].pmode, 1'b0,
               11, 10, 45, 45);
      drain(1'b1);
    end
    chk("table_rows_published", ti, 7);

    for (int f = 0; f < 8; f++) begin
      do_frame(-1, 0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, HEIGHT - 1)) : 0,
               1, 1'b1, int'($urandom_range(1, 4)), int'($urandom_range(2, 5)), 3, 3);
      drain(1'b0);
    end

    // vsync rises on the very cycle line 5 ends: abort with 4 lines, new frame
    do_frame(-1, 0, 4, 1, 1'b0, 3, 3, 3, 0);
    repeat (3) step(1'b0, 1'b0, '0);
    for (int p = 0; p < WIDTH; p++) begin
      px = gen_px(1);
      m_pix(px);
      step(1'b0, 1'b1, px);
    end
    m_vs();
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    repeat (3) step(1'b0, 1'b0, '0);
    for (int l = 0; l < HEIGHT; l++) do_line(WIDTH, 1, 3, 3);
    repeat (4) step(1'b0, 1'b0, '0);
    drain(1'b0);

    // reset during line 10 with de high across the release
    do_frame(-1, 0, 9, 1, 1'b0, 3, 3, 3, 0);
    repeat (3) step(1'b0, 1'b0, '0);
    repeat (5) step(1'b0, 1'b1, 36'h123456789);
    drain(1'b0);
    nd0 = nd;
    rst = 1'b1;
    repeat (3) step(1'b0, 1'b1, 36'h123456789);
    rst = 1'b0;
    m_open = 1'b0; m_lens.delete(); m_ec = 0;
    repeat (4) step(1'b0, 1'b1, 36'h123456789);
    repeat (3) step(1'b0, 1'b0, '0);
    chk("rst_no_frame_done", nd, nd0);
    cmp("rst_outputs", sample(), mk(0, 0, 0, 0, 0, '0), 1'b1);
    do_frame(-1, 0, 0, 0, 1'b0, 11, 10, 45, 45);
    chk("post_rst_err_cnt", int'(bus.err_cnt), 0);
    drain(1'b0);

    // back-to-back vsyncs: every rise after the first aborts an empty frame
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b0, '0);
      m_vs();
      step(1'b0, 1'b0, '0);
    end
    repeat (2) step(1'b0, 1'b0, '0);
    drain(1'b0);
    chk("err_cnt_saturated", int'(bus.err_cnt), 255);
    do_frame(-1, 0, 0, 1, 1'b0, 3, 3, 3, 4);
    drain(1'b0);
    chk("err_cnt_holds", int'(bus.err_cnt), 255);

    chk("outputs_stable_between_pulses", stab_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
